// File: rtl/wrap_ptr.sv
// Modulo-DEPTH pointer counter: advances by one on each enabled clock edge and
// wraps from DEPTH-1 back to 0.
module wrap_ptr #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == PW'(DEPTH - 1)) ptr <= '0;
      else                       ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/count_fifo.sv
// Small FIFO that queues count values from an upstream counter, with an
// occupancy level and a sticky flag for values offered while full.
module count_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic [LW-1:0] level,
  output logic          overflow
);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("count_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge exactly when valid and
  // ready are both high at that edge; neither side may depend on the other's
  // ready combinationally, and a full FIFO never passes data straight through.
  logic          push;
  logic          pop;
  logic          full;
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [W-1:0]  mem [DEPTH];

  assign full      = (level == LW'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem[head_ptr] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  wrap_ptr #(.DEPTH(DEPTH)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .ptr   (head_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push),
    .ptr   (tail_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[tail_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky until reset: any offer made while full is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                overflow <= 1'b0;
    else if (in_valid && full) overflow <= 1'b1;
  end

`ifdef FORMAL
  logic f_init = 1'b1;
  always @(posedge clk) f_init <= 1'b0;
  always @* assume (!rst_n == f_init);
`endif

  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    level <= LW'(DEPTH));

  a_valid_level: assert property (@(posedge clk) disable iff (!rst_n)
    !(out_valid && level == '0));

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

  c_full: cover property (@(posedge clk) disable iff (!rst_n)
    level == LW'(DEPTH));

endmodule

// File: tb/tb_count_fifo.sv
// Directed bench for count_fifo (W=10, DEPTH=4): reset, fill, overflow,
// simultaneous push/pop, streaming with pointer wrap, and mid-transfer reset.
module tb_count_fifo;

  localparam int W     = 10;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          overflow;

  int passed;
  int total;

  count_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"},  32'(out_data),  32'd0);
    check({tag, "_level"}, 32'(level),     32'd0);
    check({tag, "_ready"}, 32'(in_ready),  32'd1);
  endtask

  logic [W-1:0] exp_q[$];

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    drive(1'b0, '0, 1'b0);

    // Reset state
    #3;
    check_empty("rst");
    check("rst_ovf", 32'(overflow), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Push 1,2,3 with out_ready low: head held at 1
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, W'(i), 1'b0);
      step();
      check("fill_level", 32'(level), 32'(i));
      check("fill_head", 32'(out_data), 32'd1);
      check("fill_valid", 32'(out_valid), 32'd1);
    end
    check("fill_ready", 32'(in_ready), 32'd1);
    drive(1'b0, '0, 1'b0);
    step();
    check("hold_head", 32'(out_data), 32'd1);
    check("hold_level", 32'(level), 32'd3);

    // Fill to DEPTH, then offer a 5th value
    drive(1'b1, W'(4), 1'b0);
    step();
    check("full_level", 32'(level), 32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_ovf", 32'(overflow), 32'd0);
    drive(1'b1, W'(5), 1'b0);
    step();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd4);
    drive(1'b0, '0, 1'b0);
    step();
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Offer while full with out_ready high: pop only, no pass-through
    drive(1'b1, W'(9), 1'b1);
    check("full_pop_ready", 32'(in_ready), 32'd0);
    check("full_pop_head", 32'(out_data), 32'd1);
    step();
    check("full_pop_level", 32'(level), 32'd3);

    // Drain 2,3,4; the dropped 5 and 9 never appear
    drive(1'b0, '0, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      check("drain_data", 32'(out_data), 32'(i));
      step();
    end
    check_empty("drained");

    // Level 2, then simultaneous push 7 / pop
    drive(1'b1, W'(10), 1'b0);
    step();
    drive(1'b1, W'(11), 1'b0);
    step();
    check("pp_pre_level", 32'(level), 32'd2);
    drive(1'b1, W'(7), 1'b1);
    step();
    check("pp_level", 32'(level), 32'd2);
    check("pp_head", 32'(out_data), 32'd11);
    drive(1'b0, '0, 1'b1);
    step();
    check("pp_next", 32'(out_data), 32'd7);
    check("pp_next_level", 32'(level), 32'd1);
    step();
    check_empty("pp_done");

    // Stream 10 values with out_ready high; pointers wrap repeatedly
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, W'(100 + i), 1'b1);
      exp_q.push_back(W'(100 + i));
      step();
      check("stream_level", 32'(level), 32'd1);
      check("stream_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
    drive(1'b0, '0, 1'b1);
    step();
    check_empty("stream_done");
    check("stream_ovf", 32'(overflow), 32'd1);

    // Reset asserted mid-transfer at level 3, between clock edges
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(200 + i), 1'b0);
      step();
    end
    check("pre_rst_level", 32'(level), 32'd3);
    drive(1'b0, '0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_empty("async_rst");
    check("async_rst_ovf", 32'(overflow), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check_empty("post_rst");

    // First push after reset release
    drive(1'b1, W'(33), 1'b0);
    step();
    check("post_rst_push", 32'(out_data), 32'd33);
    check("post_rst_level", 32'(level), 32'd1);
    drive(1'b0, '0, 1'b0);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/count_fifo.md
COUNT_FIFO -- requirements
Module: count_fifo

Interface
REQ-001 Parameter W, default 10, data width of each queued count value.
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream counter offers in_data this cycle.
REQ-006 in_data  input  W  count value from upstream counter.
REQ-007 in_ready  output  1  FIFO accepts in_data this cycle.
REQ-008 out_valid  output  1  head entry available.
REQ-009 out_data  output  W  head entry value.
REQ-010 out_ready  input  1  downstream consumes head this cycle.
REQ-011 level  output  $clog2(DEPTH)+1  current number of stored entries.
REQ-012 overflow  output  1  sticky flag: an offered value was dropped.

Function
REQ-013 in_ready SHALL equal (level != DEPTH); no pass-through when full, even if out_ready=1.
REQ-014 Push SHALL occur on a rising edge when in_valid && in_ready; in_data is written at the tail and the tail pointer advances modulo DEPTH.
REQ-015 Pop SHALL occur on a rising edge when out_valid && out_ready; the head pointer advances modulo DEPTH.
REQ-016 Simultaneous push and pop SHALL leave level unchanged and SHALL be legal at any non-full, non-empty level.
REQ-017 out_valid SHALL equal (level != 0); a value pushed at edge n SHALL be visible on out_data after edge n (latency 1 cycle from empty).
REQ-018 out_data SHALL equal the head entry when out_valid=1 and SHALL be all-zero when out_valid=0.
REQ-019 While out_valid && !out_ready, out_data and out_valid SHALL hold stable on the next cycle.
REQ-020 Entries SHALL leave in push order (FIFO); pointers SHALL wrap from DEPTH-1 to 0 without loss.
REQ-021 overflow SHALL set on any edge with in_valid=1 and level=DEPTH; the offered value is dropped; it stays 1 until reset.
REQ-022 level SHALL never exceed DEPTH; the pop of the last entry SHALL return level to 0.
REQ-023 The block SHALL carry embedded formal properties: assume (!rst_n == $initstate); when rst_n is high, assert level <= DEPTH, assert !(out_valid && level==0), assert REQ-019 stability, and cover level==DEPTH.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear the pointers, level, overflow and all storage; the outputs SHALL read out_valid=0, out_data=0, level=0, overflow=0, in_ready=1.
REQ-025 A reset asserted mid-transfer SHALL discard all queued entries with no partial pop.
REQ-026 The first push is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-027 No shared package; the level width and pointer width SHALL be localparams derived from DEPTH.
REQ-028 One sub-module, wrap_ptr (a modulo-DEPTH pointer counter with an increment enable), SHALL be instantiated twice, for the head and tail pointers.

Verification
REQ-029 Reset, then push values 1,2,3 with out_ready=0 -> level=3, out_data=1 and held stable, in_ready=1.
REQ-030 Push 4 values with DEPTH=4, then in_valid=1 for one more cycle -> in_ready=0, overflow=1 and stays 1, level=4, the 5th value is never output.
REQ-031 At level=2, push 7 and pop in the same cycle -> level stays 2; the next two outputs are the old second entry, then 7.
REQ-032 Stream 10 values through with out_ready=1 -> the output order is identical and both pointers wrap twice without loss.
REQ-033 Assert rst_n low at level=3 -> out_valid=0, level=0 and out_data=0 immediately, without waiting for a clock edge.
REQ-034 Run the model checker on the REQ-023 properties (W=4, DEPTH=4) -> all asserts proven and the cover reached.
